// File: rtl/geometry_stream_engine.sv
// rtl/geometry_stream_engine.sv - vertex fetch, 4x4 transform, near cull, perspective divide and viewport stream engine
module geometry_stream_engine #(
    parameter int          SCREEN_W   = 320,
    parameter int          SCREEN_H   = 240,
    parameter int          FRAC_BITS  = 16,
    parameter int          DEPTH_BITS = 8,
    parameter int          FRAME_W    = 6,
    parameter int          VADDR_W    = 10,
    parameter logic [31:0] NEAR_W     = 32'h00001999
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [FRAME_W-1:0]          i_frame_sel,
    input  logic [VADDR_W-1:0]          i_base_addr,
    output logic [VADDR_W-1:0]          o_vtx_addr,
    input  logic [31:0]                 i_vtx_data,
    output logic [FRAME_W+3:0]          o_mtx_addr,
    input  logic [31:0]                 i_mtx_data,
    output logic                        o_vertex_valid,
    input  logic                        i_vertex_ready,
    output logic [$clog2(SCREEN_W)-1:0] o_x,
    output logic [$clog2(SCREEN_H)-1:0] o_y,
    output logic [DEPTH_BITS-1:0]       o_z,
    output logic [31:0]                 o_u,
    output logic [31:0]                 o_v,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [15:0]                 o_vertex_count,
    output logic [15:0]                 o_cull_count
);

    localparam int                 XW    = $clog2(SCREEN_W);
    localparam int                 YW    = $clog2(SCREEN_H);
    localparam logic [31:0]        ONE   = 32'd1 << FRAC_BITS;
    localparam logic signed [63:0] ONE64 = 64'sd1 <<< FRAC_BITS;
    localparam logic [63:0]        NUM   = 64'd1 << (2 * FRAC_BITS);
    localparam logic signed [63:0] XHALF = 64'(SCREEN_W / 2);
    localparam logic signed [63:0] YHALF = 64'(SCREEN_H / 2);
    localparam logic signed [63:0] XMAX  = 64'(SCREEN_W - 1);
    localparam logic signed [63:0] YMAX  = 64'(SCREEN_H - 1);
    localparam logic signed [63:0] ZMAX  = 64'((1 << DEPTH_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MTX_LOAD, S_VTX_LOAD, S_XFORM, S_CULL, S_RECIP, S_VIEWPORT, S_EMIT
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] frame_q;
    logic [VADDR_W-1:0] cur_addr;
    logic [4:0]         cnt;
    logic [31:0]        m [16];
    logic [31:0]        vw [5];
    logic [31:0]        vin [4];
    logic [31:0]        clip_n [4];
    logic [31:0]        clip_x, clip_y, clip_z, clip_w;
    logic [31:0]        rem, quo, num_sh;
    logic               ovf;
    logic [32:0]        trial;
    logic               take;
    logic               sentinel;
    logic [31:0]        r_eff, ndc_x, ndc_y, ndc_z;
    logic signed [63:0] sx, sy, sz;

    function automatic logic signed [63:0] clamp(input logic signed [63:0] val,
                                                 input logic signed [63:0] mx);
        if (val < 0)
            return 64'sd0;
        else if (val > mx)
            return mx;
        else
            return val;
    endfunction

    assign o_busy   = (state != S_IDLE);
    assign vin[0]   = vw[0];
    assign vin[1]   = vw[1];
    assign vin[2]   = vw[2];
    assign vin[3]   = ONE;
    assign sentinel = (vw[0] == 32'hFFFF_FFFF) && (vw[1] == 32'hFFFF_FFFF) &&
                      (vw[2] == 32'hFFFF_FFFF) && (vw[3] == 32'hFFFF_FFFF) &&
                      (i_vtx_data == 32'hFFFF_FFFF);
    // Restoring-division trial subtract: shift in the next dividend bit, keep it if the divisor fits
    assign trial    = {rem, num_sh[31]};
    assign take     = (trial >= {1'b0, clip_w});

    // Matrix times {x,y,z,ONE}: each product rescaled to fixed point, row sums wrap at 32 bits
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            clip_n[r] = '0;
            for (int c = 0; c < 4; c++)
                clip_n[r] = clip_n[r] +
                    32'((64'(signed'(m[r*4+c])) * 64'(signed'(vin[c]))) >>> FRAC_BITS);
        end
    end

    // Perspective scale by the reciprocal of w, then map [-1,1] onto the screen and depth ranges
    always_comb begin
        r_eff = ovf ? 32'h7FFF_FFFF : quo;
        ndc_x = 32'((64'(signed'(clip_x)) * signed'({32'd0, r_eff})) >>> FRAC_BITS);
        ndc_y = 32'((64'(signed'(clip_y)) * signed'({32'd0, r_eff})) >>> FRAC_BITS);
        ndc_z = 32'((64'(signed'(clip_z)) * signed'({32'd0, r_eff})) >>> FRAC_BITS);
        sx    = ((64'(signed'(ndc_x)) + ONE64) * XHALF) >>> FRAC_BITS;
        sy    = ((64'(signed'(ndc_y)) + ONE64) * YHALF) >>> FRAC_BITS;
        sz    = ((64'(signed'(ndc_z)) + ONE64) * ZMAX) >>> (FRAC_BITS + 1);
    end

    // Main sequencer: fetch matrix once per stream, then per vertex fetch/transform/cull/divide/emit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            frame_q        <= '0;
            cur_addr       <= '0;
            cnt            <= '0;
            o_vtx_addr     <= '0;
            o_mtx_addr     <= '0;
            o_vertex_valid <= 1'b0;
            o_done         <= 1'b0;
            o_vertex_count <= '0;
            o_cull_count   <= '0;
            o_x            <= '0;
            o_y            <= '0;
            o_z            <= '0;
            o_u            <= '0;
            o_v            <= '0;
            rem            <= '0;
            quo            <= '0;
            num_sh         <= '0;
            ovf            <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        frame_q        <= i_frame_sel;
                        cur_addr       <= i_base_addr;
                        o_vertex_count <= '0;
                        o_cull_count   <= '0;
                        o_mtx_addr     <= {i_frame_sel, 4'd0};
                        cnt            <= '0;
                        state          <= S_MTX_LOAD;
                    end
                end
                S_MTX_LOAD: begin
                    // Data for the address issued last cycle arrives now
                    if (cnt != 5'd0)
                        m[4'(cnt - 5'd1)] <= i_mtx_data;
                    if (cnt < 5'd15)
                        o_mtx_addr <= {frame_q, 4'(cnt + 5'd1)};
                    if (cnt == 5'd16) begin
                        cnt        <= '0;
                        o_vtx_addr <= cur_addr;
                        state      <= S_VTX_LOAD;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_VTX_LOAD: begin
                    if (cnt != 5'd0)
                        vw[3'(cnt - 5'd1)] <= i_vtx_data;
                    if (cnt < 5'd4)
                        o_vtx_addr <= o_vtx_addr + VADDR_W'(1);
                    if (cnt == 5'd5) begin
                        cnt      <= '0;
                        cur_addr <= cur_addr + VADDR_W'(5);
                        if (sentinel) begin
                            o_done <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_XFORM;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_XFORM: begin
                    clip_x <= clip_n[0];
                    clip_y <= clip_n[1];
                    clip_z <= clip_n[2];
                    clip_w <= clip_n[3];
                    state  <= S_CULL;
                end
                S_CULL: begin
                    cnt <= '0;
                    if ($signed(clip_w) < $signed(NEAR_W)) begin
                        if (o_cull_count != 16'hFFFF)
                            o_cull_count <= o_cull_count + 16'd1;
                        o_vtx_addr <= cur_addr;
                        state      <= S_VTX_LOAD;
                    end else begin
                        // Quotient wider than 31 bits cannot be represented; flag it up front
                        ovf    <= ((NUM >> 31) >= {32'd0, clip_w});
                        rem    <= NUM[63:32];
                        num_sh <= NUM[31:0];
                        quo    <= '0;
                        state  <= S_RECIP;
                    end
                end
                S_RECIP: begin
                    rem    <= take ? 32'(trial - {1'b0, clip_w}) : trial[31:0];
                    quo    <= {quo[30:0], take};
                    num_sh <= num_sh << 1;
                    if (cnt == 5'd31) begin
                        cnt   <= '0;
                        state <= S_VIEWPORT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_VIEWPORT: begin
                    o_x            <= XW'(clamp(sx, XMAX));
                    o_y            <= YW'(clamp(sy, YMAX));
                    o_z            <= DEPTH_BITS'(clamp(sz, ZMAX));
                    o_u            <= vw[3];
                    o_v            <= vw[4];
                    o_vertex_valid <= 1'b1;
                    state          <= S_EMIT;
                end
                S_EMIT: begin
                    if (i_vertex_ready) begin
                        o_vertex_valid <= 1'b0;
                        if (o_vertex_count != 16'hFFFF)
                            o_vertex_count <= o_vertex_count + 16'd1;
                        cnt        <= '0;
                        o_vtx_addr <= cur_addr;
                        state      <= S_VTX_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_geometry_stream_engine.sv
// tb/tb_geometry_stream_engine.sv - directed self-checking bench for geometry_stream_engine
module tb_geometry_stream_engine;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;
    localparam logic [31:0] NEG2 = 32'hFFFE_0000;
    localparam logic [31:0] NEG1 = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  frame_sel = '0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  vtx_addr;
    logic [31:0] vtx_data;
    logic [9:0]  mtx_addr;
    logic [31:0] mtx_data;
    logic        vvalid;
    logic        vready = 1'b1;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [7:0]  z;
    logic [31:0] u, v;
    logic        busy, done;
    logic [15:0] vcnt, ccnt;

    logic [31:0] vmem [1024];
    logic [31:0] mmem [1024];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int valid_seen = 0;
    logic [31:0] q_x[$], q_y[$], q_z[$], q_u[$], q_v[$];

    geometry_stream_engine dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_frame_sel    (frame_sel),
        .i_base_addr    (base_addr),
        .o_vtx_addr     (vtx_addr),
        .i_vtx_data     (vtx_data),
        .o_mtx_addr     (mtx_addr),
        .i_mtx_data     (mtx_data),
        .o_vertex_valid (vvalid),
        .i_vertex_ready (vready),
        .o_x            (x),
        .o_y            (y),
        .o_z            (z),
        .o_u            (u),
        .o_v            (v),
        .o_busy         (busy),
        .o_done         (done),
        .o_vertex_count (vcnt),
        .o_cull_count   (ccnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        vtx_data <= vmem[vtx_addr];
        mtx_data <= mmem[mtx_addr];
    end

    always @(negedge clk) begin
        if (vvalid && vready) begin
            q_x.push_back(32'(x));
            q_y.push_back(32'(y));
            q_z.push_back(32'(z));
            q_u.push_back(u);
            q_v.push_back(v);
        end
        if (vvalid) valid_seen++;
        if (done) done_cnt++;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int f, input logic [31:0] w33);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mmem[f*16 + r*4 + c] = (r == c) ? ((r == 3) ? w33 : ONE) : 32'd0;
    endtask

    task automatic put_vtx(input int a, input logic [31:0] vx, vy, vz, vu, vv);
        vmem[10'(a)]     = vx;
        vmem[10'(a + 1)] = vy;
        vmem[10'(a + 2)] = vz;
        vmem[10'(a + 3)] = vu;
        vmem[10'(a + 4)] = vv;
    endtask

    task automatic put_sentinel(input int a);
        for (int i = 0; i < 5; i++) vmem[10'(a + i)] = 32'hFFFF_FFFF;
    endtask

    task automatic start_stream(input int f, input int a);
        @(posedge clk); #1;
        frame_sel = 6'(f);
        base_addr = 10'(a);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        expect_eq({tag, "_done_seen"}, 64'(got), 64'd1);
        @(negedge clk);
        expect_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        expect_eq({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic run_stream(input string tag, input int f, input int a);
        start_stream(f, a);
        @(negedge clk);
        expect_eq({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(tag, 3000);
    endtask

    task automatic expect_vtx(input string tag, input int ex, ey, ez, input logic [31:0] eu, ev);
        if (q_x.size() == 0) begin
            expect_eq({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            expect_eq({tag, "_x"}, 64'(q_x.pop_front()), 64'(ex));
            expect_eq({tag, "_y"}, 64'(q_y.pop_front()), 64'(ey));
            expect_eq({tag, "_z"}, 64'(q_z.pop_front()), 64'(ez));
            expect_eq({tag, "_u"}, 64'(q_u.pop_front()), 64'(eu));
            expect_eq({tag, "_v"}, 64'(q_v.pop_front()), 64'(ev));
        end
    endtask

    task automatic check_all_zero(input string tag);
        expect_eq({tag, "_valid"}, 64'(vvalid), 64'd0);
        expect_eq({tag, "_done"}, 64'(done), 64'd0);
        expect_eq({tag, "_busy"}, 64'(busy), 64'd0);
        expect_eq({tag, "_vcnt"}, 64'(vcnt), 64'd0);
        expect_eq({tag, "_ccnt"}, 64'(ccnt), 64'd0);
        expect_eq({tag, "_x"}, 64'(x), 64'd0);
        expect_eq({tag, "_y"}, 64'(y), 64'd0);
        expect_eq({tag, "_z"}, 64'(z), 64'd0);
        expect_eq({tag, "_u"}, 64'(u), 64'd0);
        expect_eq({tag, "_v"}, 64'(v), 64'd0);
        expect_eq({tag, "_vaddr"}, 64'(vtx_addr), 64'd0);
        expect_eq({tag, "_maddr"}, 64'(mtx_addr), 64'd0);
    endtask

    initial begin
        int   vs0, dc0;
        bit   got, stable;
        logic [8:0]  x0;
        logic [7:0]  y0, z0;
        logic [31:0] u0, v0;

        for (int i = 0; i < 1024; i++) begin
            vmem[i] = '0;
            mmem[i] = '0;
        end
        set_frame(1, ONE);
        set_frame(2, 32'h0002_0000);
        set_frame(3, 32'd0);
        set_frame(5, ONE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Centre vertex through identity
        put_vtx(0, 0, 0, 0, 5, 7);
        put_sentinel(5);
        run_stream("t1", 1, 0);
        expect_vtx("t1", 160, 120, 127, 5, 7);
        expect_eq("t1_vcnt", 64'(vcnt), 64'd1);
        expect_eq("t1_ccnt", 64'(ccnt), 64'd0);
        expect_eq("t1_ndone", 64'(done_cnt), 64'd1);

        // Upper clamp, lower clamp, mid-range
        put_vtx(100, ONE, ONE, ONE, 1, 2);
        put_vtx(105, NEG2, NEG2, NEG2, 3, 4);
        put_vtx(110, HALF, HALF, HALF, 5, 6);
        put_sentinel(115);
        run_stream("t2", 1, 100);
        expect_vtx("t2a", 319, 239, 255, 1, 2);
        expect_vtx("t2b", 0, 0, 0, 3, 4);
        expect_vtx("t2c", 240, 180, 191, 5, 6);
        expect_eq("t2_vcnt", 64'(vcnt), 64'd3);

        // w = 2.0 exercises the reciprocal
        put_vtx(200, ONE, NEG1, 0, 7, 8);
        put_sentinel(205);
        run_stream("t2w", 2, 200);
        expect_vtx("t2w", 240, 60, 127, 7, 8);

        // w = 0 culls every vertex
        vs0 = valid_seen;
        put_vtx(300, ONE, ONE, ONE, 1, 1);
        put_vtx(305, 0, 0, 0, 2, 2);
        put_sentinel(310);
        run_stream("t3", 3, 300);
        expect_eq("t3_ccnt", 64'(ccnt), 64'd2);
        expect_eq("t3_vcnt", 64'(vcnt), 64'd0);
        expect_eq("t3_no_valid", 64'(valid_seen - vs0), 64'd0);

        // Back-pressure: outputs must hold while ready is low
        vready = 1'b0;
        put_vtx(400, 0, 0, 0, 9, 11);
        put_sentinel(405);
        start_stream(1, 400);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (vvalid) got = 1'b1;
        end
        expect_eq("t4_valid_seen", 64'(got), 64'd1);
        x0 = x; y0 = y; z0 = z; u0 = u; v0 = v;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!vvalid || x !== x0 || y !== y0 || z !== z0 || u !== u0 || v !== v0 || vcnt !== 16'd0)
                stable = 1'b0;
        end
        expect_eq("t4_stable", 64'(stable), 64'd1);
        @(posedge clk); #1;
        vready = 1'b1;
        wait_done("t4", 300);
        expect_eq("t4_vcnt", 64'(vcnt), 64'd1);
        expect_vtx("t4", 160, 120, 127, 9, 11);

        // Reset in the middle of the divide
        put_vtx(500, 0, 0, 0, 21, 22);
        put_sentinel(505);
        start_stream(1, 500);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
        vs0 = valid_seen;
        dc0 = done_cnt;
        repeat (60) @(negedge clk);
        expect_eq("t5_no_valid", 64'(valid_seen - vs0), 64'd0);
        expect_eq("t5_no_done", 64'(done_cnt - dc0), 64'd0);
        start_stream(5, 500);
        @(negedge clk);
        expect_eq("t5_frame", 64'(mtx_addr[9:4]), 64'd5);
        expect_eq("t5_index", 64'(mtx_addr[3:0]), 64'd0);
        wait_done("t5", 3000);
        expect_vtx("t5", 160, 120, 127, 21, 22);
        expect_eq("t5_vcnt", 64'(vcnt), 64'd1);

        // Address wrap from the top of vertex memory
        put_vtx(1019, 0, 0, 0, 1, 2);
        put_vtx(0, HALF, HALF, HALF, 3, 4);
        put_sentinel(5);
        run_stream("t6", 1, 1019);
        expect_vtx("t6a", 160, 120, 127, 1, 2);
        expect_vtx("t6b", 240, 180, 191, 3, 4);
        expect_eq("t6_vcnt", 64'(vcnt), 64'd2);
        expect_eq("t6_qempty", 64'(q_x.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
